ps2_rx_fifo: RTL and testbench

Parametrised PS/2 device-to-host receiver with glitch filter, timeout recovery, full frame checking and a buffered ready/valid output. Replaces the single-register, pulse-output keyboard decoder. Samples the PS/2 lines entirely in the system clock domain, so no logic is clocked by the PS/2 clock. Sits between the PS/2 connector pins and the CPU/peripheral bus keyboard register.

---
 rtl/ps2_pkg.sv | 15 +
 rtl/ps2_sync_fifo.sv | 49 ++++
 rtl/ps2_rx_fifo.sv | 220 ++++++++++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam int DATA_BITS = 8;
  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

endpackage

// File: rtl/ps2_sync_fifo.sv
// First-word fall-through FIFO; depth must be a power of two so pointers wrap naturally.
module ps2_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic [WIDTH-1:0]               wdata,
  input  logic                           pop,
  output logic [WIDTH-1:0]               rdata,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is still accepted when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: sync, glitch filter, frame FSM with timeout, FWFT byte FIFO.
// Define PS2_PREFIX_STRIP_EN to fold E0/F0 prefixes into rx_ext/rx_brk flags.
//
// state     | meaning
// ST_IDLE   | waiting for a start bit (data 0 at a falling filtered clock)
// ST_DATA   | shifting in 8 data bits, LSB first
// ST_PARITY | checking the odd-parity bit
// ST_STOP   | checking the stop bit, then push or report an error
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FILTER_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  inout  wire                               ps2_clk,
  inout  wire                               ps2_data,
  output logic [7:0]                        rx_data,
  output logic                              rx_ext,
  output logic                              rx_brk,
  output logic                              rx_valid,
  input  logic                              rx_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
  output logic                              parity_err,
  output logic                              frame_err,
  output logic                              timeout_err,
  output logic                              overflow
);

  localparam int FLT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]       BIT_LAST = 3'(DATA_BITS - 1);

  assign ps2_clk  = 1'bz;
  assign ps2_data = 1'bz;

  logic [1:0]       clk_s;
  logic [1:0]       data_s;
  logic             clk_f;
  logic             clk_f_d;
  logic [FLT_W-1:0] flt_cnt;
  logic             strobe;
  logic             data_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s   <= 2'b11;
      data_s  <= 2'b11;
      clk_f   <= 1'b1;
      clk_f_d <= 1'b1;
      flt_cnt <= '0;
    end else begin
      clk_s   <= {clk_s[0], ps2_clk};
      data_s  <= {data_s[0], ps2_data};
      clk_f_d <= clk_f;
      if (clk_s[1] == clk_f) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FLT_LAST) begin
        clk_f   <= clk_s[1];
        flt_cnt <= '0;
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end
  end

  assign strobe   = clk_f_d & ~clk_f;
  assign data_bit = data_s[1];

  ps2_state_e      state, state_n;
  logic [7:0]      shift_q;
  logic [2:0]      bit_idx;
  logic            par_acc;
  logic            par_ok;
  logic [TO_W-1:0] to_cnt;
  logic            frame_ok;
  logic            perr_n, ferr_n, terr_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    frame_ok = 1'b0;
    perr_n   = 1'b0;
    ferr_n   = 1'b0;
    terr_n   = 1'b0;
    case (state)
      ST_IDLE:   if (strobe && !data_bit) state_n = ST_DATA;
      ST_DATA:   if (strobe && bit_idx == BIT_LAST) state_n = ST_PARITY;
      ST_PARITY: if (strobe) state_n = ST_STOP;
      ST_STOP: begin
        if (strobe) begin
          state_n = ST_IDLE;
          if (!data_bit)    ferr_n   = 1'b1;
          else if (!par_ok) perr_n   = 1'b1;
          else              frame_ok = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    if (state != ST_IDLE && !strobe && to_cnt == TO_LAST) begin
      state_n = ST_IDLE;
      terr_n  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      bit_idx <= '0;
      par_acc <= 1'b0;
      par_ok  <= 1'b0;
      to_cnt  <= '0;
    end else begin
      if (state == ST_IDLE || strobe) to_cnt <= '0;
      else                            to_cnt <= to_cnt + 1'b1;
      if (strobe) begin
        case (state)
          ST_IDLE: begin
            bit_idx <= '0;
            par_acc <= 1'b0;
          end
          ST_DATA: begin
            shift_q <= {data_bit, shift_q[7:1]};
            par_acc <= par_acc ^ data_bit;
            bit_idx <= bit_idx + 1'b1;
          end
          ST_PARITY: par_ok <= par_acc ^ data_bit;
          default: ;
        endcase
      end
    end
  end

  logic fifo_push;
  logic fifo_full;
  logic fifo_empty;

`ifdef PS2_PREFIX_STRIP_EN
  logic [DATA_BITS+1:0] fifo_wdata;
  logic [DATA_BITS+1:0] fifo_rdata;
  logic                 ext_pend;
  logic                 brk_pend;
  logic                 is_ext;
  logic                 is_brk;

  assign is_ext     = (shift_q == PS2_PREFIX_EXT);
  assign is_brk     = (shift_q == PS2_PREFIX_BRK);
  assign fifo_push  = frame_ok && !is_ext && !is_brk;
  assign fifo_wdata = {ext_pend, brk_pend, shift_q};
  assign {rx_ext, rx_brk, rx_data} = fifo_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
    end else if (perr_n || ferr_n || terr_n) begin
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
    end else if (frame_ok) begin
      if (is_ext) begin
        ext_pend <= 1'b1;
      end else if (is_brk) begin
        brk_pend <= 1'b1;
      end else begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end
    end
  end

  ps2_sync_fifo #(.WIDTH(DATA_BITS + 2), .DEPTH(FIFO_DEPTH)) u_fifo (
`else
  logic [DATA_BITS-1:0] fifo_wdata;
  logic [DATA_BITS-1:0] fifo_rdata;

  assign fifo_push  = frame_ok;
  assign fifo_wdata = shift_q;
  assign rx_data    = fifo_rdata;
  assign rx_ext     = 1'b0;
  assign rx_brk     = 1'b0;

  ps2_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
`endif
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (rx_ready),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign rx_valid = !fifo_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      timeout_err <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      parity_err  <= perr_n;
      frame_err   <= ferr_n;
      timeout_err <= terr_n;
      // Full implies non-empty, so rx_ready alone means the head leaves this cycle.
      overflow    <= fifo_push && fifo_full && !rx_ready;
    end
  end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: table of single frames plus timeout, glitch, overflow, prefix and reset sequences.
module tb_ps2_rx_fifo;

  localparam int HALF = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk_drv = 1'b1;
  logic       ps2_data_drv = 1'b1;
  wire        ps2_clk_w;
  wire        ps2_data_w;
  logic [7:0] rx_data;
  logic       rx_ext, rx_brk, rx_valid;
  logic       rx_ready = 1'b0;
  logic [3:0] fifo_level;
  logic       parity_err, frame_err, timeout_err, overflow;

  assign ps2_clk_w  = ps2_clk_drv;
  assign ps2_data_w = ps2_data_drv;

  always #10 clk = ~clk;

  ps2_rx_fifo #(.FILTER_CYCLES(16), .TIMEOUT_CYCLES(5000), .FIFO_DEPTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .ps2_clk     (ps2_clk_w),
    .ps2_data    (ps2_data_w),
    .rx_data     (rx_data),
    .rx_ext      (rx_ext),
    .rx_brk      (rx_brk),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .fifo_level  (fifo_level),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .timeout_err (timeout_err),
    .overflow    (overflow)
  );

  int n_perr = 0, n_ferr = 0, n_terr = 0, n_ovf = 0;
  always @(negedge clk) begin
    if (parity_err)  n_perr++;
    if (frame_err)   n_ferr++;
    if (timeout_err) n_terr++;
    if (overflow)    n_ovf++;
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic ps2_bit(input logic b, input bit glitch);
    ps2_data_drv = b;
    if (glitch) begin
      repeat (HALF/2) @(posedge clk);
      ps2_clk_drv = 1'b0;
      repeat (10) @(posedge clk);
      ps2_clk_drv = 1'b1;
      repeat (HALF/2) @(posedge clk);
    end else begin
      repeat (HALF) @(posedge clk);
    end
    ps2_clk_drv = 1'b0;
    repeat (HALF) @(posedge clk);
    ps2_clk_drv = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit flip_par, input bit bad_stop,
                            input bit glitch, input int nbits);
    logic [10:0] f;
    f = {~bad_stop, (~^b) ^ flip_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(f[i], glitch);
    ps2_data_drv = 1'b1;
    repeat (HALF) @(posedge clk);
  endtask

  task automatic pop_expect(input string name, input logic [7:0] exp);
    @(negedge clk);
    check({name, "_valid"}, int'(rx_valid), 1);
    check({name, "_data"}, int'(rx_data), int'(exp));
    rx_ready = 1'b1;
    @(posedge clk);
    #1 rx_ready = 1'b0;
  endtask

  typedef struct {
    logic [7:0] data;
    bit         flip_par;
    bit         bad_stop;
    int         exp_perr;
    int         exp_ferr;
    int         exp_level;
    logic [7:0] exp_head;
  } vec_t;

  vec_t vecs[5];
  logic [7:0] ovf_bytes[9];

  initial begin
    int p0, f0, t0, o0;
    vecs[0] = '{8'h1C, 1'b0, 1'b0, 0, 0, 1, 8'h1C};
    vecs[1] = '{8'h1C, 1'b1, 1'b0, 1, 0, 1, 8'h1C};
    vecs[2] = '{8'h32, 1'b0, 1'b0, 0, 0, 2, 8'h1C};
    vecs[3] = '{8'h45, 1'b0, 1'b1, 0, 1, 2, 8'h1C};
    vecs[4] = '{8'h45, 1'b1, 1'b1, 0, 1, 2, 8'h1C};
    for (int i = 0; i < 9; i++) ovf_bytes[i] = 8'(8'h10 + 8'(i * 7));

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_valid", int'(rx_valid), 0);
    check("rst_data", int'(rx_data), 0);
    check("rst_level", int'(fifo_level), 0);
    check("rst_flags", int'({rx_ext, rx_brk, parity_err, frame_err, timeout_err, overflow}), 0);

    for (int i = 0; i < 5; i++) begin
      p0 = n_perr; f0 = n_ferr; t0 = n_terr;
      send_frame(vecs[i].data, vecs[i].flip_par, vecs[i].bad_stop, 1'b0, 11);
      @(negedge clk);
      check($sformatf("vec%0d_perr", i), n_perr - p0, vecs[i].exp_perr);
      check($sformatf("vec%0d_ferr", i), n_ferr - f0, vecs[i].exp_ferr);
      check($sformatf("vec%0d_terr", i), n_terr - t0, 0);
      check($sformatf("vec%0d_level", i), int'(fifo_level), vecs[i].exp_level);
      check($sformatf("vec%0d_head", i), int'(rx_data), int'(vecs[i].exp_head));
      check($sformatf("vec%0d_valid", i), int'(rx_valid), 1);
    end
    pop_expect("drain0", 8'h1C);
    pop_expect("drain1", 8'h32);
    @(negedge clk);
    check("drain_empty", int'(rx_valid), 0);

    // stall after 4 data bits, then 120 us idle
    t0 = n_terr;
    send_frame(8'h29, 1'b0, 1'b0, 1'b0, 5);
    repeat (6000) @(posedge clk);
    @(negedge clk);
    check("to_pulse", n_terr - t0, 1);
    check("to_level", int'(fifo_level), 0);
    send_frame(8'h29, 1'b0, 1'b0, 1'b0, 11);
    @(negedge clk);
    check("to_next_level", int'(fifo_level), 1);
    pop_expect("to_next", 8'h29);

    p0 = n_perr; f0 = n_ferr; t0 = n_terr;
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 11);
    @(negedge clk);
    check("glitch_level", int'(fifo_level), 1);
    check("glitch_errs", (n_perr - p0) + (n_ferr - f0) + (n_terr - t0), 0);
    pop_expect("glitch", 8'h5A);

    o0 = n_ovf;
    for (int i = 0; i < 8; i++) send_frame(ovf_bytes[i], 1'b0, 1'b0, 1'b0, 11);
    @(negedge clk);
    check("full_level", int'(fifo_level), 8);
    check("full_no_ovf", n_ovf - o0, 0);
    send_frame(ovf_bytes[8], 1'b0, 1'b0, 1'b0, 11);
    @(negedge clk);
    check("ovf_pulse", n_ovf - o0, 1);
    check("ovf_level", int'(fifo_level), 8);
    rx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("ovf_out%0d", i), int'({rx_valid, rx_data}), int'({1'b1, ovf_bytes[i]}));
      @(negedge clk);
    end
    check("ovf_drained", int'(rx_valid), 0);
    repeat (3) @(negedge clk);
    check("pop_empty_level", int'(fifo_level), 0);
    rx_ready = 1'b0;

    send_frame(8'hE0, 1'b0, 1'b0, 1'b0, 11);
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0, 11);
    send_frame(8'h75, 1'b0, 1'b0, 1'b0, 11);
    @(negedge clk);
`ifdef PS2_PREFIX_STRIP_EN
    check("pfx_level", int'(fifo_level), 1);
    check("pfx_head", int'({rx_ext, rx_brk, rx_data}), int'({2'b11, 8'h75}));
    pop_expect("pfx", 8'h75);
`else
    check("pfx_level", int'(fifo_level), 3);
    check("pfx_flags", int'({rx_ext, rx_brk}), 0);
    pop_expect("pfx0", 8'hE0);
    pop_expect("pfx1", 8'hF0);
    pop_expect("pfx2", 8'h75);
`endif

    send_frame(8'h11, 1'b0, 1'b0, 1'b0, 11);
    t0 = n_terr;
    send_frame(8'h33, 1'b0, 1'b0, 1'b0, 4);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid_level", int'(fifo_level), 0);
    check("rst_mid_valid", int'(rx_valid), 0);
    send_frame(8'h22, 1'b0, 1'b0, 1'b0, 11);
    repeat (6000) @(posedge clk);
    @(negedge clk);
    check("rst_mid_no_to", n_terr - t0, 0);
    check("rst_mid_next_level", int'(fifo_level), 1);
    pop_expect("rst_mid_next", 8'h22);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
